// File: rtl/alu_op_sequencer.sv
// Operand/opcode sequencer: accepts one instruction, drives the ALU, returns the result over valid/ready.
// Optional completed-operation counter enabled by defining ALU_SEQ_OP_COUNT_EN.
module alu_op_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int OPRN_WIDTH = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  INSTR_VALID,
  output logic                  INSTR_READY,
  input  logic [31:0]           INSTR,
  input  logic [DATA_WIDTH-1:0] RS_DATA,
  input  logic [DATA_WIDTH-1:0] RT_DATA,
  output logic [DATA_WIDTH-1:0] ALU_OP1,
  output logic [DATA_WIDTH-1:0] ALU_OP2,
  output logic [OPRN_WIDTH-1:0] ALU_OPRN,
  input  logic [DATA_WIDTH-1:0] ALU_OUT,
  input  logic                  ALU_ZERO,
  output logic                  RES_VALID,
  input  logic                  RES_READY,
  output logic [DATA_WIDTH-1:0] RES_DATA,
  output logic                  RES_ZERO,
  output logic [4:0]            RES_DEST,
  output logic                  RES_ILLEGAL,
  output logic [31:0]           OP_COUNT
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, RESP} state_t;

  localparam logic [OPRN_WIDTH-1:0] OPRN_ADD = OPRN_WIDTH'(1);
  localparam logic [OPRN_WIDTH-1:0] OPRN_SUB = OPRN_WIDTH'(2);
  localparam logic [OPRN_WIDTH-1:0] OPRN_MUL = OPRN_WIDTH'(3);
  localparam logic [OPRN_WIDTH-1:0] OPRN_SRL = OPRN_WIDTH'(4);
  localparam logic [OPRN_WIDTH-1:0] OPRN_SLL = OPRN_WIDTH'(5);
  localparam logic [OPRN_WIDTH-1:0] OPRN_AND = OPRN_WIDTH'(6);
  localparam logic [OPRN_WIDTH-1:0] OPRN_OR  = OPRN_WIDTH'(7);
  localparam logic [OPRN_WIDTH-1:0] OPRN_NOR = OPRN_WIDTH'(8);
  localparam logic [OPRN_WIDTH-1:0] OPRN_SLT = OPRN_WIDTH'(9);

  state_t                  state_q;
  logic [31:0]             instr_q;
  logic [DATA_WIDTH-1:0]   rs_q, rt_q;
  logic [DATA_WIDTH-1:0]   op1_q, op2_q, res_data_q;
  logic [OPRN_WIDTH-1:0]   oprn_q;
  logic [4:0]              dest_pend_q, dest_q;
  logic                    illegal_pend_q, illegal_q;
  logic                    res_valid_q, res_zero_q;

  logic [DATA_WIDTH-1:0]   op1_d, op2_d;
  logic [OPRN_WIDTH-1:0]   oprn_d;
  logic [4:0]              dest_d;
  logic                    illegal_d;

  logic [5:0]  op_f, funct_f;
  logic [4:0]  rt_f, rd_f, shamt_f;
  logic [15:0] imm_f;
  logic        unused_rs_field;

  assign op_f    = instr_q[31:26];
  assign rt_f    = instr_q[20:16];
  assign rd_f    = instr_q[15:11];
  assign shamt_f = instr_q[10:6];
  assign funct_f = instr_q[5:0];
  assign imm_f   = instr_q[15:0];
  // Register contents arrive on RS_DATA/RT_DATA, so the rs index itself is never needed.
  assign unused_rs_field = ^instr_q[25:21];

  assign INSTR_READY = RST && (state_q == IDLE);

  // Capture instruction and register data on acceptance.
  always_ff @(posedge CLK) begin
    if (INSTR_VALID && INSTR_READY) begin
      instr_q <= INSTR;
      rs_q    <= RS_DATA;
      rt_q    <= RT_DATA;
    end
  end

  always_comb begin
    oprn_d    = '0;
    op1_d     = '0;
    op2_d     = '0;
    dest_d    = '0;
    illegal_d = 1'b1;
    if (op_f == 6'h00) begin
      illegal_d = 1'b0;
      dest_d    = rd_f;
      op1_d     = rs_q;
      op2_d     = rt_q;
      case (funct_f)
        6'h20: oprn_d = OPRN_ADD;
        6'h22: oprn_d = OPRN_SUB;
        6'h2C: oprn_d = OPRN_MUL;
        6'h24: oprn_d = OPRN_AND;
        6'h25: oprn_d = OPRN_OR;
        6'h27: oprn_d = OPRN_NOR;
        6'h2A: oprn_d = OPRN_SLT;
        6'h02, 6'h01: begin
          oprn_d = (funct_f == 6'h02) ? OPRN_SRL : OPRN_SLL;
          op1_d  = rt_q;
          op2_d  = {{(DATA_WIDTH-5){1'b0}}, shamt_f};
        end
        default: begin
          illegal_d = 1'b1;
          dest_d    = '0;
          op1_d     = '0;
          op2_d     = '0;
        end
      endcase
    end else begin
      case (op_f)
        6'h08, 6'h1D, 6'h0A: begin
          illegal_d = 1'b0;
          dest_d    = rt_f;
          op1_d     = rs_q;
          op2_d     = {{(DATA_WIDTH-16){imm_f[15]}}, imm_f};
          oprn_d    = (op_f == 6'h08) ? OPRN_ADD : (op_f == 6'h1D) ? OPRN_MUL : OPRN_SLT;
        end
        6'h0C, 6'h0D: begin
          illegal_d = 1'b0;
          dest_d    = rt_f;
          op1_d     = rs_q;
          op2_d     = {{(DATA_WIDTH-16){1'b0}}, imm_f};
          oprn_d    = (op_f == 6'h0C) ? OPRN_AND : OPRN_OR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= IDLE;
      oprn_q         <= '0;
      op1_q          <= '0;
      op2_q          <= '0;
      dest_pend_q    <= '0;
      illegal_pend_q <= 1'b0;
      dest_q         <= '0;
      illegal_q      <= 1'b0;
      res_data_q     <= '0;
      res_zero_q     <= 1'b0;
      res_valid_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (INSTR_VALID) begin
            illegal_q <= 1'b0;
            state_q   <= DECODE;
          end
        end
        // Decode -> ALU operand stage
        DECODE: begin
          oprn_q         <= oprn_d;
          op1_q          <= op1_d;
          op2_q          <= op2_d;
          dest_pend_q    <= dest_d;
          illegal_pend_q <= illegal_d;
          state_q        <= EXEC;
        end
        // ALU result capture stage
        EXEC: begin
          res_data_q  <= illegal_pend_q ? '0 : ALU_OUT;
          res_zero_q  <= illegal_pend_q ? 1'b0 : ALU_ZERO;
          dest_q      <= dest_pend_q;
          illegal_q   <= illegal_pend_q;
          res_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (RES_READY) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ALU_OPRN    = oprn_q;
  assign ALU_OP1     = op1_q;
  assign ALU_OP2     = op2_q;
  assign RES_VALID   = res_valid_q;
  assign RES_DATA    = res_data_q;
  assign RES_ZERO    = res_zero_q;
  assign RES_DEST    = dest_q;
  assign RES_ILLEGAL = illegal_q;

`ifdef ALU_SEQ_OP_COUNT_EN
  logic [31:0] op_count_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      op_count_q <= '0;
    end else if (res_valid_q && RES_READY && !illegal_q && (op_count_q != 32'hFFFF_FFFF)) begin
      op_count_q <= op_count_q + 32'd1;
    end
  end

  assign OP_COUNT = op_count_q;
`else
  assign OP_COUNT = '0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU attached to the operand outputs.
module tb_alu_op_sequencer;

  localparam int DW = 32;
`ifdef ALU_SEQ_OP_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          INSTR_VALID = 1'b0;
  logic          INSTR_READY;
  logic [31:0]   INSTR = '0;
  logic [DW-1:0] RS_DATA = '0, RT_DATA = '0;
  logic [DW-1:0] ALU_OP1, ALU_OP2, ALU_OUT, RES_DATA;
  logic [5:0]    ALU_OPRN;
  logic          ALU_ZERO, RES_VALID, RES_READY = 1'b0, RES_ZERO, RES_ILLEGAL;
  logic [4:0]    RES_DEST;
  logic [31:0]   OP_COUNT;

  int checks = 0;
  int errors = 0;
  int legal_ops = 0;

  alu_op_sequencer #(.DATA_WIDTH(DW), .OPRN_WIDTH(6)) dut (
    .CLK(CLK), .RST(RST), .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
    .INSTR(INSTR), .RS_DATA(RS_DATA), .RT_DATA(RT_DATA),
    .ALU_OP1(ALU_OP1), .ALU_OP2(ALU_OP2), .ALU_OPRN(ALU_OPRN),
    .ALU_OUT(ALU_OUT), .ALU_ZERO(ALU_ZERO),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
    .RES_ZERO(RES_ZERO), .RES_DEST(RES_DEST), .RES_ILLEGAL(RES_ILLEGAL),
    .OP_COUNT(OP_COUNT)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    case (ALU_OPRN)
      6'd1:    ALU_OUT = ALU_OP1 + ALU_OP2;
      6'd2:    ALU_OUT = ALU_OP1 - ALU_OP2;
      6'd3:    ALU_OUT = ALU_OP1 * ALU_OP2;
      6'd4:    ALU_OUT = ALU_OP1 >> ALU_OP2[4:0];
      6'd5:    ALU_OUT = ALU_OP1 << ALU_OP2[4:0];
      6'd6:    ALU_OUT = ALU_OP1 & ALU_OP2;
      6'd7:    ALU_OUT = ALU_OP1 | ALU_OP2;
      6'd8:    ALU_OUT = ~(ALU_OP1 | ALU_OP2);
      6'd9:    ALU_OUT = ($signed(ALU_OP1) < $signed(ALU_OP2)) ? 32'd1 : 32'd0;
      default: ALU_OUT = 32'hDEAD_BEEF;
    endcase
    ALU_ZERO = (ALU_OUT == '0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] exp_count();
    return CNT_EN ? 32'(legal_ops) : 32'd0;
  endfunction

  // One full transaction: accept, check operands, check result, complete handshake.
  task automatic run_op(input string tag, input logic [31:0] ins, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [5:0] e_oprn,
                        input logic [31:0] e_op1, input logic [31:0] e_op2,
                        input logic [31:0] e_data, input logic e_zero, input logic [4:0] e_dest);
    @(negedge CLK);
    INSTR = ins; RS_DATA = rs; RT_DATA = rt; INSTR_VALID = 1'b1;
    chk({tag, " ready_idle"}, 32'(INSTR_READY), 32'd1);
    step();
    INSTR_VALID = 1'b0;
    chk({tag, " ready_busy"}, 32'(INSTR_READY), 32'd0);
    step();
    chk({tag, " oprn"}, 32'(ALU_OPRN), 32'(e_oprn));
    chk({tag, " op1"}, ALU_OP1, e_op1);
    chk({tag, " op2"}, ALU_OP2, e_op2);
    chk({tag, " valid_early"}, 32'(RES_VALID), 32'd0);
    step();
    chk({tag, " valid"}, 32'(RES_VALID), 32'd1);
    chk({tag, " data"}, RES_DATA, e_data);
    chk({tag, " zero"}, 32'(RES_ZERO), 32'(e_zero));
    chk({tag, " dest"}, 32'(RES_DEST), 32'(e_dest));
    chk({tag, " illegal"}, 32'(RES_ILLEGAL), 32'd0);
    RES_READY = 1'b1;
    step();
    RES_READY = 1'b0;
    legal_ops++;
    chk({tag, " valid_drop"}, 32'(RES_VALID), 32'd0);
    chk({tag, " ready_back"}, 32'(INSTR_READY), 32'd1);
    chk({tag, " op_count"}, OP_COUNT, exp_count());
  endtask

  initial begin
    logic [31:0] cnt_before;

    #2;
    chk("rst ready", 32'(INSTR_READY), 32'd0);
    chk("rst valid", 32'(RES_VALID), 32'd0);
    chk("rst oprn", 32'(ALU_OPRN), 32'd0);
    chk("rst op1", ALU_OP1, 32'd0);
    chk("rst data", RES_DATA, 32'd0);
    chk("rst count", OP_COUNT, 32'd0);
    step();
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("post-rst ready", 32'(INSTR_READY), 32'd1);

    run_op("add",  32'h0022_1820, 32'd5, 32'd7, 6'd1, 32'd5, 32'd7, 32'd12, 1'b0, 5'd3);
    run_op("sub",  32'h0022_1822, 32'd9, 32'd9, 6'd2, 32'd9, 32'd9, 32'd0, 1'b1, 5'd3);
    run_op("addi", 32'h2022_FFFF, 32'd1, 32'd0, 6'd1, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 5'd2);
    run_op("ori",  32'h3422_FFFF, 32'h1234_0000, 32'd0, 6'd7, 32'h1234_0000, 32'h0000_FFFF,
           32'h1234_FFFF, 1'b0, 5'd2);
    run_op("sll",  32'h0002_20C1, 32'd0, 32'd1, 6'd5, 32'd1, 32'd3, 32'd8, 1'b0, 5'd4);
    run_op("srl",  32'h0002_20C2, 32'd0, 32'h80, 6'd4, 32'h80, 32'd3, 32'h10, 1'b0, 5'd4);
    run_op("slt",  32'h0022_182A, 32'hFFFF_FFFF, 32'd1, 6'd9, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 5'd3);
    run_op("andi", 32'h3022_80F0, 32'hFFFF_FFFF, 32'd0, 6'd6, 32'hFFFF_FFFF, 32'h0000_80F0,
           32'h0000_80F0, 1'b0, 5'd2);
    run_op("muli", 32'h7422_FFFE, 32'd3, 32'd0, 6'd3, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFA, 1'b0, 5'd2);

    // Illegal opcode under backpressure; a second request must be ignored.
    cnt_before = OP_COUNT;
    @(negedge CLK);
    INSTR = 32'hFC00_0000; RS_DATA = 32'd5; RT_DATA = 32'd6; INSTR_VALID = 1'b1;
    step();
    INSTR = 32'h0022_1820;
    step();
    chk("ill oprn", 32'(ALU_OPRN), 32'd0);
    chk("ill op1", ALU_OP1, 32'd0);
    chk("ill op2", ALU_OP2, 32'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp valid", 32'(RES_VALID), 32'd1);
      chk("bp illegal", 32'(RES_ILLEGAL), 32'd1);
      chk("bp data", RES_DATA, 32'd0);
      chk("bp zero", 32'(RES_ZERO), 32'd0);
      chk("bp dest", 32'(RES_DEST), 32'd0);
      chk("bp ready", 32'(INSTR_READY), 32'd0);
      step();
    end
    INSTR_VALID = 1'b0;
    RES_READY = 1'b1;
    step();
    RES_READY = 1'b0;
    chk("ill done valid", 32'(RES_VALID), 32'd0);
    chk("ill done ready", 32'(INSTR_READY), 32'd1);
    chk("ill count", OP_COUNT, cnt_before);
    step();
    step();
    chk("ignored req valid", 32'(RES_VALID), 32'd0);
    chk("ignored req oprn", 32'(ALU_OPRN), 32'd0);
    chk("ignored req ready", 32'(INSTR_READY), 32'd1);

    // Reset asserted while in EXEC.
    @(negedge CLK);
    INSTR = 32'h0022_1820; RS_DATA = 32'd5; RT_DATA = 32'd7; INSTR_VALID = 1'b1;
    step();
    INSTR_VALID = 1'b0;
    step();
    RST = 1'b0;
    #1;
    chk("midrst ready", 32'(INSTR_READY), 32'd0);
    chk("midrst valid", 32'(RES_VALID), 32'd0);
    chk("midrst oprn", 32'(ALU_OPRN), 32'd0);
    chk("midrst op1", ALU_OP1, 32'd0);
    chk("midrst op2", ALU_OP2, 32'd0);
    chk("midrst data", RES_DATA, 32'd0);
    chk("midrst dest", 32'(RES_DEST), 32'd0);
    chk("midrst illegal", 32'(RES_ILLEGAL), 32'd0);
    chk("midrst count", OP_COUNT, 32'd0);
    legal_ops = 0;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("midrst release ready", 32'(INSTR_READY), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("midrst no result", 32'(RES_VALID), 32'd0);
    end

    run_op("post1", 32'h0022_1820, 32'd1, 32'd2, 6'd1, 32'd1, 32'd2, 32'd3, 1'b0, 5'd3);
    run_op("post2", 32'h0022_1824, 32'hF0, 32'h3C, 6'd6, 32'hF0, 32'h3C, 32'h30, 1'b0, 5'd3);
    run_op("post3", 32'h0022_1827, 32'd0, 32'd0, 6'd8, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 5'd3);
    chk("final count", OP_COUNT, CNT_EN ? 32'd3 : 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
